// File: rtl/ntt_twiddle_gen_if.sv
// Twiddle generator port bundle: command (start/p/omega/log_n), status, and the valid/ready output stream.
// master = generator side, slave = controller/consumer side.
interface ntt_twiddle_gen_if #(
   parameter int WIDTH     = 64,
   parameter int LOG_N_MAX = 6
);
   localparam int LW = $clog2(LOG_N_MAX + 1);

   logic                 start;
   logic [WIDTH-1:0]     p;
   logic [WIDTH-1:0]     omega;
   logic [LW-1:0]        log_n;
   logic                 busy;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     out_data;
   logic [LOG_N_MAX-1:0] out_idx;
   logic                 done;
   logic                 err;

   modport master (
      input  start, p, omega, log_n, out_ready,
      output busy, out_valid, out_data, out_idx, done, err
   );

   modport slave (
      output start, p, omega, log_n, out_ready,
      input  busy, out_valid, out_data, out_idx, done, err
   );
endinterface

// File: rtl/ntt_twiddle_gen.sv
// Streams omega^k mod p, k=0..2^log_n-1, via a bit-serial shift-add modmul; first beat 1 cycle after start, then WIDTH+1 cycles/beat.
// out_* hold while out_valid && !out_ready. Define NTT_TWIDDLE_BITREV_EN for bit-reversed out_idx.
module ntt_twiddle_gen #(
   parameter int WIDTH     = 64,
   parameter int LOG_N_MAX = 6
) (
   input logic               clk,
   input logic               rst,
   ntt_twiddle_gen_if.master tw
);
   localparam int LW = $clog2(LOG_N_MAX + 1);
   localparam int BW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, EMIT, MUL} state_t;

   state_t               state;
   logic [WIDTH-1:0]     p_q;
   logic [WIDTH-1:0]     omega_q;
   logic [LW-1:0]        log_n_q;
   logic [WIDTH-1:0]     cur;
   logic [WIDTH-1:0]     acc;
   logic [BW-1:0]        bit_idx;
   logic [LOG_N_MAX-1:0] k;

   logic [WIDTH:0]       dbl;
   logic [WIDTH:0]       dbl_red;
   logic [WIDTH:0]       sum;
   logic [WIDTH-1:0]     acc_nxt;
   logic [LOG_N_MAX-1:0] k_nxt;
   logic [LOG_N_MAX-1:0] k_last;
   logic [LOG_N_MAX:0]   seq_len;
   logic [LOG_N_MAX-1:0] idx_nxt;
   logic                 param_bad;

   assign param_bad = (tw.p < WIDTH'(2)) || (tw.omega >= tw.p) ||
                      (32'(tw.log_n) > 32'(LOG_N_MAX));

   // One interleaved step: acc = (2*acc + omega[bit]*cur) mod p; acc < p keeps both reductions single-subtract.
   always_comb begin
      dbl     = {acc, 1'b0};
      dbl_red = (dbl >= {1'b0, p_q}) ? dbl - {1'b0, p_q} : dbl;
      sum     = omega_q[bit_idx] ? dbl_red + {1'b0, cur} : dbl_red;
      acc_nxt = (sum >= {1'b0, p_q}) ? WIDTH'(sum - {1'b0, p_q}) : WIDTH'(sum);
   end

   always_comb begin
      seq_len = (LOG_N_MAX + 1)'(1) << log_n_q;
      k_last  = LOG_N_MAX'(seq_len - 1'b1);
      k_nxt   = k + 1'b1;
   end

`ifdef NTT_TWIDDLE_BITREV_EN
   logic [LOG_N_MAX-1:0] k_rev;

   // Full-width reversal then right shift leaves k reversed over the low log_n bits, upper bits zero.
   always_comb begin
      k_rev = '0;
      for (int i = 0; i < LOG_N_MAX; i++) begin
         k_rev[i] = k_nxt[LOG_N_MAX-1-i];
      end
      idx_nxt = k_rev >> (LOG_N_MAX - int'(log_n_q));
   end
`else
   always_comb begin
      idx_nxt = k_nxt;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         p_q          <= '0;
         omega_q      <= '0;
         log_n_q      <= '0;
         cur          <= '0;
         acc          <= '0;
         bit_idx      <= '0;
         k            <= '0;
         tw.busy      <= 1'b0;
         tw.out_valid <= 1'b0;
         tw.out_data  <= '0;
         tw.out_idx   <= '0;
         tw.done      <= 1'b0;
         tw.err       <= 1'b0;
      end else begin
         tw.done <= 1'b0;
         case (state)
            IDLE: begin
               if (tw.start) begin
                  p_q     <= tw.p;
                  omega_q <= tw.omega;
                  log_n_q <= tw.log_n;
                  tw.err  <= param_bad;
                  if (!param_bad) begin
                     cur          <= WIDTH'(1);
                     k            <= '0;
                     tw.out_data  <= WIDTH'(1);
                     tw.out_idx   <= '0;
                     tw.out_valid <= 1'b1;
                     tw.busy      <= 1'b1;
                     state        <= EMIT;
                  end
               end
            end
            EMIT: begin
               if (tw.out_ready) begin
                  tw.out_valid <= 1'b0;
                  if (k == k_last) begin
                     tw.done <= 1'b1;
                     tw.busy <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     acc     <= '0;
                     bit_idx <= BW'(WIDTH - 1);
                     state   <= MUL;
                  end
               end
            end
            MUL: begin
               acc     <= acc_nxt;
               bit_idx <= bit_idx - 1'b1;
               if (bit_idx == '0) begin
                  cur          <= acc_nxt;
                  k            <= k_nxt;
                  tw.out_data  <= acc_nxt;
                  tw.out_idx   <= idx_nxt;
                  tw.out_valid <= 1'b1;
                  state        <= EMIT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
